div_stall_unit: RTL and testbench

//  Multi-cycle restoring divider for MIPS DIV/DIVU in the E stage. Initiates pipeline stalls.
//  It raises stall_divE toward the hazard unit. The hazard unit ORs it into stallF/stallD/stallE
//  and holds the issuing instruction in E.
//  The 2*WIDTH result {hi,lo} is presented to the HI/LO write path for exactly one cycle.

---
 rtl/div_stall_unit.sv | 129 ++++++++++++
 tb/tb_div_stall_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/div_stall_unit.sv
// Multi-cycle restoring divider for DIV/DIVU in the E stage; stalls the pipeline while iterating.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and goes straight to DONE.
module div_stall_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startE,
  input  logic               signedE,
  input  logic               annulE,
  input  logic [WIDTH-1:0]   opaE,
  input  logic [WIDTH-1:0]   opbE,
  output logic               stall_divE,
  output logic               readyE,
  output logic [2*WIDTH-1:0] resultE
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic               sa, sb, ge;
  logic [WIDTH-1:0]   mag_a, mag_b, diff, quo_fix, rem_fix;
  logic [WIDTH:0]     shifted;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    res_d      = res_q;
    stall_divE = 1'b0;
    readyE     = 1'b0;

    sa    = signedE & opaE[WIDTH-1];
    sb    = signedE & opbE[WIDTH-1];
    mag_a = sa ? -opaE : opaE;
    mag_b = sb ? -opbE : opbE;

    // quo_q doubles as the dividend shift register; its MSB feeds the partial remainder.
    shifted = {rem_q, quo_q[WIDTH-1]};
    ge      = shifted >= {1'b0, dvs_q};
    diff    = shifted[WIDTH-1:0] - dvs_q;

    quo_fix = qneg_q ? -quo_q : quo_q;
    rem_fix = rneg_q ? -rem_q : rem_q;

    case (state_q)
      IDLE: begin
        if (startE && !annulE) begin
          stall_divE = 1'b1;
          dvs_d      = mag_b;
          quo_d      = mag_a;
          rem_d      = '0;
          qneg_d     = sa ^ sb;
          rneg_d     = sa;
          cnt_d      = '0;
          state_d    = BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (opbE == '0) begin
            quo_d   = '1;
            rem_d   = mag_a;
            state_d = DONE;
          end
`endif
        end
      end
      BUSY: begin
        if (annulE) begin
          state_d = IDLE;
        end else begin
          stall_divE = 1'b1;
          rem_d      = ge ? diff : shifted[WIDTH-1:0];
          quo_d      = {quo_q[WIDTH-2:0], ge};
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1))
            state_d = DONE;
        end
      end
      DONE: begin
        // The issuing instruction is still in E here, so startE is deliberately ignored.
        state_d = IDLE;
        if (!annulE) begin
          readyE = 1'b1;
          res_d  = {rem_fix, quo_fix};
        end
      end
      default: state_d = IDLE;
    endcase

    resultE = readyE ? {rem_fix, quo_fix} : res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_div_stall_unit.sv
// Directed bench for div_stall_unit; honours DIV_ZERO_FAST_EN for divide-by-zero latency.
module tb_div_stall_unit;
  logic        clk = 1'b0;
  logic        rst, startE, signedE, annulE;
  logic [31:0] opaE, opbE;
  logic        stall_divE, readyE;
  logic [63:0] resultE;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  div_stall_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .startE(startE), .signedE(signedE), .annulE(annulE),
    .opaE(opaE), .opbE(opbE), .stall_divE(stall_divE), .readyE(readyE), .resultE(resultE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one division in the current cycle and waits for its ready pulse.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n = 0;
    int stall_miss = 0;
    startE = 1'b1; signedE = sgn; opaE = a; opbE = b;
    #1;
    while (!readyE && n < 100) begin
      if (!stall_divE) stall_miss++;
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " stall held"}, 64'(stall_miss), 64'd0);
    check({tag, " stall low at ready"}, 64'(stall_divE), 64'd0);
    check({tag, " result"}, resultE, exp);
    startE = 1'b0;
    tick();
    check({tag, " ready one cycle"}, 64'(readyE), 64'd0);
    check({tag, " result held"}, resultE, exp);
  endtask

  initial begin
    int ready_cnt;
    int second_at;
    rst = 1'b1; startE = 1'b0; signedE = 1'b0; annulE = 1'b0; opaE = '0; opbE = '0;
    tick(); tick();
    check("reset stall", 64'(stall_divE), 64'd0);
    check("reset ready", 64'(readyE), 64'd0);
    check("reset result", resultE, 64'd0);
    rst = 1'b0;
    tick();

    do_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    do_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    do_div("divu -7 bits/2", 1'b0, 32'hFFFFFFF9, 32'd2, {32'd1, 32'h7FFFFFFC}, 33);
    do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33);
    do_div("div overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33);
    do_div("divu 5/0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, ZLAT);
    do_div("div -5/0", 1'b1, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'd1}, ZLAT);

    // Annul in the middle of the iterations.
    startE = 1'b1; signedE = 1'b0; opaE = 32'd999; opbE = 32'd3;
    for (int i = 0; i < 10; i++) tick();
    check("annul busy stall before", 64'(stall_divE), 64'd1);
    annulE = 1'b1;
    #1;
    check("annul stall drops", 64'(stall_divE), 64'd0);
    check("annul no ready", 64'(readyE), 64'd0);
    check("annul result kept", resultE, {32'hFFFFFFFB, 32'd1});
    tick();
    annulE = 1'b0; startE = 1'b0;
    ready_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (readyE) ready_cnt++;
      tick();
    end
    check("annul no later ready", 64'(ready_cnt), 64'd0);
    do_div("after annul 999/3", 1'b0, 32'd999, 32'd3, {32'd0, 32'd333}, 33);

    // Reset while iterating.
    startE = 1'b1; signedE = 1'b0; opaE = 32'd50; opbE = 32'd5;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1; startE = 1'b0;
    tick();
    rst = 1'b0;
    ready_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (readyE) ready_cnt++;
      tick();
    end
    check("rst mid busy no ready", 64'(ready_cnt), 64'd0);
    check("rst mid busy result", resultE, 64'd0);

    // startE stays high through DONE; the next div follows immediately.
    startE = 1'b1; signedE = 1'b0; opaE = 32'd81; opbE = 32'd9;
    #1;
    begin
      int n = 0;
      while (!readyE && n < 100) begin tick(); n++; end
      check("b2b first latency", 64'(n), 64'd33);
      check("b2b first result", resultE, {32'd0, 32'd9});
    end
    opaE = 32'd1000; opbE = 32'd10;
    ready_cnt = 1; second_at = -1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (readyE) begin
        ready_cnt++;
        if (second_at < 0) begin
          second_at = k;
          check("b2b second result", resultE, {32'd0, 32'd100});
          startE = 1'b0;
        end
      end
    end
    check("b2b ready pulses", 64'(ready_cnt), 64'd2);
    check("b2b spacing", 64'(second_at), 64'd34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
